lc_transition_seq: RTL and testbench

LC_TRANSITION_SEQ -- requirements
Module: lc_transition_seq

---
 rtl/lc_seq_pkg.sv | 49 ++++
 rtl/lc_trans_legal.sv | 22 ++
 rtl/lc_transition_seq.sv | 133 +++++++++++++
 tb/tb_lc_transition_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lc_seq_pkg.sv
// rtl/lc_seq_pkg.sv - lifecycle transition sequencer types and constants
package lc_seq_pkg;

    typedef enum logic [4:0] {
        DecLcStRaw           = 5'd0,
        DecLcStTestUnlocked0 = 5'd1,
        DecLcStTestLocked0   = 5'd2,
        DecLcStTestUnlocked1 = 5'd3,
        DecLcStTestLocked1   = 5'd4,
        DecLcStTestUnlocked2 = 5'd5,
        DecLcStTestLocked2   = 5'd6,
        DecLcStTestUnlocked3 = 5'd7,
        DecLcStTestLocked3   = 5'd8,
        DecLcStTestUnlocked4 = 5'd9,
        DecLcStTestLocked4   = 5'd10,
        DecLcStTestUnlocked5 = 5'd11,
        DecLcStTestLocked5   = 5'd12,
        DecLcStTestUnlocked6 = 5'd13,
        DecLcStTestLocked6   = 5'd14,
        DecLcStTestUnlocked7 = 5'd15,
        DecLcStDev           = 5'd16,
        DecLcStProd          = 5'd17,
        DecLcStProdEnd       = 5'd18,
        DecLcStRma           = 5'd19,
        DecLcStScrap         = 5'd20,
        DecLcStPostTrans     = 5'd21,
        DecLcStEscalate      = 5'd22,
        DecLcStInvalid       = 5'd23
    } dec_lc_state_e;

    typedef enum logic [2:0] {
        ErrNone    = 3'd0,
        ErrIllegal = 3'd1,
        ErrOtp     = 3'd2,
        ErrTimeout = 3'd3,
        ErrCnt     = 3'd4
    } trans_err_e;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCheck = 3'd1,
        StProg  = 3'd2,
        StDone  = 3'd3,
        StError = 3'd4
    } seq_state_e;

    localparam logic [4:0] CntSat = 5'd31;

endpackage

// File: rtl/lc_trans_legal.sv
// rtl/lc_trans_legal.sv - combinational legality check for a lifecycle transition
module lc_trans_legal
    import lc_seq_pkg::*;
(
    input  logic [4:0] target_i,
    input  logic [4:0] current_i,
    output logic       legal_o
);

    logic target_in_range;
    logic target_forward;
    logic current_ok;

    always_comb begin
        target_in_range = (target_i >= DecLcStTestUnlocked0) && (target_i <= DecLcStScrap);
        // Scrap is reachable from any non-terminal state; everything else only moves forward.
        target_forward  = (target_i == DecLcStScrap) || (target_i > current_i);
        current_ok      = (current_i < DecLcStPostTrans);
        legal_o         = target_in_range && target_forward && current_ok;
    end

endmodule

// File: rtl/lc_transition_seq.sv
// rtl/lc_transition_seq.sv - lifecycle transition sequencer; LC_TRANS_CNT_LIMIT_EN enables the transition count limit
module lc_transition_seq
    import lc_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned CNT_MAX     = 24
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [4:0] req_target_i,
    input  logic [4:0] cur_state_i,
    output logic       otp_req_o,
    output logic [4:0] otp_state_o,
    input  logic       otp_ack_i,
    input  logic       otp_err_i,
    output logic       done_o,
    output logic [2:0] err_o,
    output logic [4:0] trans_cnt_o
);

    localparam int unsigned TmrW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYC - 1);
    localparam logic [4:0] CntLimit  = 5'(CNT_MAX);
`ifdef LC_TRANS_CNT_LIMIT_EN
    localparam bit CntLimitEn = 1'b1;
`else
    localparam bit CntLimitEn = 1'b0;
`endif

    seq_state_e      state_q, state_d;
    logic [4:0]      target_q, target_d;
    logic [4:0]      cur_q, cur_d;
    trans_err_e      err_q, err_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            legal;
    logic            cnt_blocked;

    lc_trans_legal u_legal (
        .target_i  (target_q),
        .current_i (cur_q),
        .legal_o   (legal)
    );

    // Constant-false in the default build, so the limit logic folds away.
    assign cnt_blocked = CntLimitEn && (cnt_q >= CntLimit);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cur_d    = cur_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        tmr_d    = '0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    target_d = req_target_i;
                    cur_d    = cur_state_i;
                    err_d    = ErrNone;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (cnt_blocked) begin
                    err_d   = ErrCnt;
                    state_d = StError;
                end else if (!legal) begin
                    err_d   = ErrIllegal;
                    state_d = StError;
                end else begin
                    state_d = StProg;
                end
            end
            StProg: begin
                // An ack in the final timeout cycle still wins over the timeout.
                if (otp_ack_i) begin
                    if (otp_err_i) begin
                        err_d   = ErrOtp;
                        state_d = StError;
                    end else begin
                        if (cnt_q != CntSat) begin
                            cnt_d = cnt_q + 5'd1;
                        end
                        err_d   = ErrNone;
                        state_d = StDone;
                    end
                end else if (tmr_q == TmrLast) begin
                    err_d   = ErrTimeout;
                    state_d = StError;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StDone, StError: begin
                err_d   = ErrNone;
                state_d = StIdle;
            end
            default: begin
                err_d   = ErrNone;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            target_q <= '0;
            cur_q    <= '0;
            err_q    <= ErrNone;
            cnt_q    <= '0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cur_q    <= cur_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign otp_req_o   = (state_q == StProg);
    assign otp_state_o = target_q;
    assign done_o      = (state_q == StDone) || (state_q == StError);
    assign err_o       = err_q;
    assign trans_cnt_o = cnt_q;

endmodule

// File: tb/tb_lc_transition_seq.sv
// tb/tb_lc_transition_seq.sv - self-checking bench for lc_transition_seq
module tb_lc_transition_seq;
    import lc_seq_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [4:0] req_target_i;
    logic [4:0] cur_state_i;
    logic       otp_req_o;
    logic [4:0] otp_state_o;
    logic       otp_ack_i;
    logic       otp_err_i;
    logic       done_o;
    logic [2:0] err_o;
    logic [4:0] trans_cnt_o;

    typedef struct packed {
        logic [2:0] err;
        logic [4:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cnt_m  = 0;

    always #5 clk_i = ~clk_i;

    lc_transition_seq dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_target_i (req_target_i),
        .cur_state_i  (cur_state_i),
        .otp_req_o    (otp_req_o),
        .otp_state_o  (otp_state_o),
        .otp_ack_i    (otp_ack_i),
        .otp_err_i    (otp_err_i),
        .done_o       (done_o),
        .err_o        (err_o),
        .trans_cnt_o  (trans_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit legal_m(int cur, int tgt);
        return (tgt >= 1) && (tgt <= 20) && ((tgt == 20) || (tgt > cur)) && (cur < 21);
    endfunction

    // Scoreboard side: every completion pulse consumes one expectation.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_err", 32'(err_o), 32'(mon_e.err));
                chk("done_cnt", 32'(trans_cnt_o), 32'(mon_e.cnt));
            end
        end
    end

    // ack_wait < 0 means never acknowledge.
    task automatic do_req(input int cur, input int tgt, input int ack_wait, input bit ack_err);
        bit   legal;
        bit   blocked;
        int   experr;
        int   n;
        exp_t e;
        legal = legal_m(cur, tgt);
`ifdef LC_TRANS_CNT_LIMIT_EN
        blocked = (cnt_m >= 24);
`else
        blocked = 1'b0;
`endif
        if (blocked) experr = 4;
        else if (!legal) experr = 1;
        else if (ack_wait < 0) experr = 3;
        else if (ack_err) experr = 2;
        else begin
            experr = 0;
            cnt_m  = (cnt_m < 31) ? cnt_m + 1 : 31;
        end
        chk("ready_idle", 32'(req_ready_o), 32'd1);
        req_valid_i  = 1'b1;
        req_target_i = 5'(tgt);
        cur_state_i  = 5'(cur);
        @(posedge clk_i);
        e.err = 3'(experr);
        e.cnt = 5'(cnt_m);
        exp_q.push_back(e);
        #1;
        req_valid_i = 1'b0;
        chk("ready_low_check", 32'(req_ready_o), 32'd0);
        chk("otp_req_low_check", 32'(otp_req_o), 32'd0);
        step();
        if (blocked || !legal) begin
            chk("done_2cyc", 32'(done_o), 32'd1);
            chk("otp_req_never", 32'(otp_req_o), 32'd0);
            step();
        end else begin
            chk("otp_req_hi", 32'(otp_req_o), 32'd1);
            chk("otp_state", 32'(otp_state_o), 32'(tgt));
            if (ack_wait < 0) begin
                n = 0;
                while (otp_req_o === 1'b1 && n < 1000) begin
                    n++;
                    step();
                end
                chk("timeout_cycles", 32'(n), 32'd256);
                chk("timeout_done", 32'(done_o), 32'd1);
                step();
            end else begin
                repeat (ack_wait) step();
                chk("otp_state_stable", 32'(otp_state_o), 32'(tgt));
                chk("otp_req_hold", 32'(otp_req_o), 32'd1);
                otp_ack_i = 1'b1;
                otp_err_i = ack_err;
                step();
                otp_ack_i = 1'b0;
                otp_err_i = 1'b0;
                chk("done_after_ack", 32'(done_o), 32'd1);
                step();
            end
        end
        chk("done_one_cycle", 32'(done_o), 32'd0);
        chk("back_idle", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_target_i = '0;
        cur_state_i  = '0;
        otp_ack_i    = 1'b0;
        otp_err_i    = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_otp_req", 32'(otp_req_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_cnt", 32'(trans_cnt_o), 32'd0);
        rst_ni = 1'b1;
        step();

        otp_ack_i = 1'b1;
        step();
        step();
        otp_ack_i = 1'b0;
        chk("stray_ack_cnt", 32'(trans_cnt_o), 32'd0);
        chk("stray_ack_ready", 32'(req_ready_o), 32'd1);

        do_req(0, 1, 3, 1'b0);
        chk("first_cnt", 32'(trans_cnt_o), 32'd1);
        do_req(17, 16, 0, 1'b0);
        do_req(16, 20, 1, 1'b1);
        chk("otp_err_cnt", 32'(trans_cnt_o), 32'd1);
        do_req(1, 2, -1, 1'b0);
        do_req(21, 20, 0, 1'b0);
        do_req(5, 0, 0, 1'b0);
        do_req(5, 21, 0, 1'b0);
        do_req(9, 9, 0, 1'b0);
        do_req(20, 20, 2, 1'b0);

        req_valid_i  = 1'b1;
        req_target_i = 5'd16;
        cur_state_i  = 5'd0;
        step();
        req_valid_i = 1'b0;
        step();
        chk("rstprog_otp_hi", 32'(otp_req_o), 32'd1);
        rst_ni = 1'b0;
        step();
        chk("rstprog_otp_low", 32'(otp_req_o), 32'd0);
        chk("rstprog_ready", 32'(req_ready_o), 32'd1);
        chk("rstprog_no_done", 32'(done_o), 32'd0);
        chk("rstprog_cnt", 32'(trans_cnt_o), 32'd0);
        rst_ni = 1'b1;
        cnt_m  = 0;
        step();
        chk("rstprog_no_done2", 32'(done_o), 32'd0);

        for (int i = 0; i < 24; i++) do_req(0, 1, 0, 1'b0);
        chk("cnt_24", 32'(trans_cnt_o), 32'd24);
        do_req(0, 1, 0, 1'b0);
`ifdef LC_TRANS_CNT_LIMIT_EN
        chk("cnt_limit_25th", 32'(trans_cnt_o), 32'd24);
`else
        chk("cnt_25", 32'(trans_cnt_o), 32'd25);
`endif
        for (int i = 0; i < 7; i++) do_req(0, 1, 0, 1'b0);
        chk("cnt_final", 32'(trans_cnt_o), 32'(cnt_m));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

endmodule
